// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath: FETCH/DECODE/EXEC/MEM/WB control with separate fetch and data handshakes.
// Define MC_DATAPATH_BRANCH_EXT_EN to add BNE/BLT/BGE alongside BEQ; without it those encodings halt as illegal.
module mc_datapath #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter logic [XLEN-1:0] INITIAL_PC = XLEN'(32'h00400000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            iReq,
  output logic [XLEN-1:0] iAddr,
  input  logic            iReady,
  input  logic [31:0]     instr,
  output logic            dReq,
  output logic            dWe,
  output logic [XLEN-1:0] dAddress,
  output logic [XLEN-1:0] dWriteData,
  input  logic            dReady,
  input  logic [XLEN-1:0] dReadData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] WriteBackData,
  output logic            retire,
  output logic            illegal
);
  localparam int              RW      = $clog2(NREGS);
  localparam int              SW      = $clog2(XLEN);
  localparam logic [5:0]      NREGS_L = 6'(NREGS);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_ALUI, OP_ALUR, OP_BR, OP_BAD} op_t;

  state_t          r_state;
  op_t             r_op;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_imm, r_alu, r_wbdata;
  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_taken, r_retire, r_illegal, r_ireq, r_dreq, r_dwe;

  logic [6:0]      w_opc, w_f7, w_sh_hi;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd, w_rs1, w_rs2;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm, w_opb, w_alu, w_addr, w_target;
  logic [SW-1:0]   w_shamt;
  logic            w_use_rd, w_use_rs2, w_legal, w_lt, w_taken;
  op_t             w_op;

  assign w_opc   = r_ir[6:0];
  assign w_rd    = r_ir[11:7];
  assign w_f3    = r_ir[14:12];
  assign w_rs1   = r_ir[19:15];
  assign w_rs2   = r_ir[24:20];
  assign w_f7    = r_ir[31:25];
  // On 64-bit builds IR[25] is the top shamt bit, so it is excluded from the funct check.
  assign w_sh_hi = (XLEN == 64) ? {r_ir[31:26], 1'b0} : r_ir[31:25];
  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  function automatic logic in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREGS_L;
  endfunction

  function automatic logic [XLEN-1:0] rd_reg(input logic [4:0] idx);
    return in_range(idx) ? r_regs[idx[RW-1:0]] : '0;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_op      = OP_BAD;
    w_use_rd  = 1'b0;
    w_use_rs2 = 1'b0;
    w_imm     = '0;
    case (w_opc)
      7'b0000011: if (w_f3 == 3'b010) begin
        w_op = OP_LW; w_use_rd = 1'b1; w_imm = w_imm_i;
      end
      7'b0100011: if (w_f3 == 3'b010) begin
        w_op = OP_SW; w_use_rs2 = 1'b1; w_imm = w_imm_s;
      end
      7'b0010011: if ((w_f3 == 3'b001 && w_sh_hi == 7'h00) ||
                      (w_f3 == 3'b101 && (w_sh_hi == 7'h00 || w_sh_hi == 7'h20)) ||
                      (w_f3 != 3'b001 && w_f3 != 3'b101 && w_f3 != 3'b011)) begin
        w_op = OP_ALUI; w_use_rd = 1'b1; w_imm = w_imm_i;
      end
      7'b0110011: if ((w_f7 == 7'h00 && w_f3 != 3'b011) ||
                      (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101))) begin
        w_op = OP_ALUR; w_use_rd = 1'b1; w_use_rs2 = 1'b1;
      end
`ifdef MC_DATAPATH_BRANCH_EXT_EN
      7'b1100011: if (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b100 || w_f3 == 3'b101) begin
        w_op = OP_BR; w_use_rs2 = 1'b1; w_imm = w_imm_b;
      end
`else
      7'b1100011: if (w_f3 == 3'b000) begin
        w_op = OP_BR; w_use_rs2 = 1'b1; w_imm = w_imm_b;
      end
`endif
      default: ;
    endcase
    w_legal = (w_op != OP_BAD) && in_range(w_rs1) &&
              (!w_use_rs2 || in_range(w_rs2)) && (!w_use_rd || in_range(w_rd));
  end

  assign w_opb    = (r_op == OP_ALUR || r_op == OP_BR) ? r_b : r_imm;
  assign w_shamt  = (r_op == OP_ALUR) ? r_b[SW-1:0] : r_ir[20 +: SW];
  assign w_lt     = $signed(r_a) < $signed(w_opb);
  assign w_addr   = r_a + r_imm;
  assign w_target = r_pc + r_imm;

  always_comb begin
    w_alu   = '0;
    w_taken = 1'b0;
    case (w_f3)
      3'b000:  w_alu = (r_op == OP_ALUR && r_ir[30]) ? r_a - w_opb : r_a + w_opb;
      3'b010:  w_alu = {{(XLEN-1){1'b0}}, w_lt};
      3'b100:  w_alu = r_a ^ w_opb;
      3'b110:  w_alu = r_a | w_opb;
      3'b111:  w_alu = r_a & w_opb;
      3'b001:  w_alu = r_a << w_shamt;
      3'b101:  w_alu = r_ir[30] ? $unsigned($signed(r_a) >>> w_shamt) : r_a >> w_shamt;
      default: ;
    endcase
    case (w_f3)
      3'b000:  w_taken = (r_a == r_b);
      3'b001:  w_taken = (r_a != r_b);
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = !w_lt;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= OP_BAD;
      r_pc      <= INITIAL_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_imm     <= '0;
      r_alu     <= '0;
      r_wbdata  <= '0;
      r_taken   <= 1'b0;
      r_retire  <= 1'b0;
      r_illegal <= 1'b0;
      r_ireq    <= 1'b0;
      r_dreq    <= 1'b0;
      r_dwe     <= 1'b0;
      // NOTE: the register file is architecturally zeroed on reset, so it is built from flops, not RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_ireq) begin
            r_ireq <= 1'b1;
          end else if (iReady) begin
            r_ir    <= instr;
            r_ireq  <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a   <= rd_reg(w_rs1);
          r_b   <= rd_reg(w_rs2);
          r_imm <= w_imm;
          r_op  <= w_op;
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end
        end
        S_EXEC: begin
          r_taken <= w_taken;
          if (r_op == OP_BR && w_taken && w_target[1:0] != 2'b00) begin
            r_illegal <= 1'b1;
            r_state   <= S_HALT;
          end else if (r_op == OP_LW || r_op == OP_SW) begin
            r_alu   <= w_addr;
            r_dreq  <= 1'b1;
            r_dwe   <= (r_op == OP_SW);
            r_state <= S_MEM;
          end else begin
            r_alu    <= (r_op == OP_BR) ? w_target : w_alu;
            r_retire <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_MEM: begin
          if (r_dreq && dReady) begin
            if (r_op == OP_LW) r_alu <= dReadData;
            r_dreq   <= 1'b0;
            r_dwe    <= 1'b0;
            r_retire <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_WB: begin
          if (r_op != OP_SW && r_op != OP_BR && w_rd != 5'd0) begin
            r_regs[w_rd[RW-1:0]] <= r_alu;
            r_wbdata             <= r_alu;
          end
          r_pc     <= (r_op == OP_BR && r_taken) ? r_alu : r_pc + PC_STEP;
          r_retire <= 1'b0;
          r_ireq   <= 1'b1;
          r_state  <= S_FETCH;
        end
        S_HALT:  ;
        default: r_state <= S_HALT;
      endcase
    end
  end

  assign iReq          = r_ireq;
  assign iAddr         = r_pc;
  assign dReq          = r_dreq;
  assign dWe           = r_dwe;
  assign dAddress      = r_alu;
  assign dWriteData    = r_b;
  assign PC            = r_pc;
  assign WriteBackData = r_wbdata;
  assign retire        = r_retire;
  assign illegal       = r_illegal;
endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: hand-encoded instructions with hand-computed results, latencies and PCs.
module tb_mc_datapath;
  localparam logic [31:0] INIT = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iReq, iReady, dReq, dWe, dReady, retire, illegal;
  logic [31:0] iAddr, instr, dAddress, dWriteData, dReadData, PC, WriteBackData;
  logic [31:0] dmem [64];

  logic        iReq16, iReady16, dReq16, dWe16, retire16, illegal16;
  logic [31:0] iAddr16, instr16, dAddress16, dWriteData16, PC16, WriteBackData16;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        g_overlap = 1'b0;
  logic        g_mem_stable, g_mem_we;
  logic [31:0] g_mem_addr, g_mem_wdata;

  always #5 clk = ~clk;

  assign dReadData = dmem[dAddress[7:2]];

  mc_datapath u_dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .instr(instr),
    .dReq(dReq), .dWe(dWe), .dAddress(dAddress), .dWriteData(dWriteData),
    .dReady(dReady), .dReadData(dReadData),
    .PC(PC), .WriteBackData(WriteBackData), .retire(retire), .illegal(illegal)
  );

  mc_datapath #(.NREGS(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .iReq(iReq16), .iAddr(iAddr16), .iReady(iReady16), .instr(instr16),
    .dReq(dReq16), .dWe(dWe16), .dAddress(dAddress16), .dWriteData(dWriteData16),
    .dReady(1'b0), .dReadData(32'h0),
    .PC(PC16), .WriteBackData(WriteBackData16), .retire(retire16), .illegal(illegal16)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iReady = 1'b0; dReady = 1'b0; iReady16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fetch cycle is cycle 1; lat is the cycle in which retire is seen, -1 if none (e.g. halted).
  task automatic do_instr(input logic [31:0] ins, input int dlat, output int lat);
    int wait_cnt;
    int mem_cnt;
    lat = -1; g_mem_stable = 1'b1; g_mem_we = 1'b0; g_mem_addr = '0; g_mem_wdata = '0;
    wait_cnt = 0;
    while (!iReq && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!iReq) begin
      n_checks++; n_errors++;
      $display("FAIL fetch_timeout: iReq=%b required 1", iReq);
      return;
    end
    instr = ins; iReady = 1'b1;
    @(negedge clk);
    iReady = 1'b0;
    mem_cnt = 0;
    for (int c = 2; c < 40; c++) begin
      if (iReq && dReq) g_overlap = 1'b1;
      if (dReq) begin
        if (mem_cnt == 0) begin
          g_mem_addr = dAddress; g_mem_we = dWe; g_mem_wdata = dWriteData;
        end else if (dAddress !== g_mem_addr || dWe !== g_mem_we) begin
          g_mem_stable = 1'b0;
        end
        dReady = (mem_cnt >= dlat);
        if (dReady && dWe) dmem[dAddress[7:2]] = dWriteData;
        mem_cnt++;
      end else begin
        dReady = 1'b0;
      end
      if (retire) begin
        lat = c;
        return;
      end
      if (illegal) return;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (PC !== INIT) begin n_errors++; $display("FAIL reset_pc: got %h required %h", PC, INIT); end
    n_checks++; if (WriteBackData !== 32'h0) begin n_errors++; $display("FAIL reset_wbdata: got %h required 0", WriteBackData); end
    n_checks++; if ({iReq, dReq, dWe} !== 3'b000) begin n_errors++; $display("FAIL reset_req: got %b required 000", {iReq, dReq, dWe}); end
    n_checks++; if ({retire, illegal} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b required 00", {retire, illegal}); end
  endtask

  task automatic test_addi();
    int lat;
    do_instr(32'hFFB00093, 0, lat);                       // ADDI x1,x0,-5
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL addi_latency: got %0d required 4", lat); end
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'hFFFFFFFB) begin n_errors++; $display("FAIL addi_wb: got %h required fffffffb", WriteBackData); end
    n_checks++; if (PC !== INIT + 32'h4) begin n_errors++; $display("FAIL addi_pc: got %h required %h", PC, INIT + 32'h4); end
  endtask

  task automatic test_load_store();
    int lat;
    do_instr(32'h00102423, 3, lat);                       // SW x1,8(x0)
    n_checks++; if (lat !== 8) begin n_errors++; $display("FAIL sw_latency: got %0d required 8", lat); end
    n_checks++; if (g_mem_addr !== 32'h8) begin n_errors++; $display("FAIL sw_addr: got %h required 8", g_mem_addr); end
    n_checks++; if ({g_mem_we, g_mem_stable} !== 2'b11) begin n_errors++; $display("FAIL sw_we_held: got %b required 11", {g_mem_we, g_mem_stable}); end
    n_checks++; if (dmem[2] !== 32'hFFFFFFFB) begin n_errors++; $display("FAIL sw_data: got %h required fffffffb", dmem[2]); end
    do_instr(32'h00802103, 3, lat);                       // LW x2,8(x0)
    n_checks++; if (lat !== 8) begin n_errors++; $display("FAIL lw_latency: got %0d required 8", lat); end
    n_checks++; if ({g_mem_we, g_mem_stable} !== 2'b01) begin n_errors++; $display("FAIL lw_we_held: got %b required 01", {g_mem_we, g_mem_stable}); end
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'hFFFFFFFB) begin n_errors++; $display("FAIL lw_wb: got %h required fffffffb", WriteBackData); end
    do_instr(32'h00208233, 0, lat);                       // ADD x4,x1,x2
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'hFFFFFFF6) begin n_errors++; $display("FAIL add_x1_x2: got %h required fffffff6", WriteBackData); end
    n_checks++; if (PC !== INIT + 32'h10) begin n_errors++; $display("FAIL ldst_pc: got %h required %h", PC, INIT + 32'h10); end
    n_checks++; if (g_overlap !== 1'b0) begin n_errors++; $display("FAIL req_overlap: got %b required 0", g_overlap); end
  endtask

  task automatic test_branch();
    int lat;
    do_instr(32'hFE000CE3, 0, lat);                       // BEQ x0,x0,-8 at 0x00400010
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL beq_latency: got %0d required 4", lat); end
    @(negedge clk);
    n_checks++; if (PC !== 32'h00400008) begin n_errors++; $display("FAIL beq_taken_pc: got %h required 00400008", PC); end
    n_checks++; if (WriteBackData !== 32'hFFFFFFF6) begin n_errors++; $display("FAIL beq_no_wb: got %h required fffffff6", WriteBackData); end
    do_instr(32'h00300113, 0, lat);                       // ADDI x2,x0,3
    do_instr(32'h0020A333, 0, lat);                       // SLT x6,x1,x2 (-5 < 3 signed)
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'h1) begin n_errors++; $display("FAIL slt_signed: got %h required 1", WriteBackData); end
    do_instr(32'h00208863, 0, lat);                       // BEQ x1,x2,+16 at 0x00400010, not taken
    @(negedge clk);
    n_checks++; if (PC !== 32'h00400014) begin n_errors++; $display("FAIL beq_not_taken_pc: got %h required 00400014", PC); end
  endtask

  task automatic test_branch_ext();
    int lat;
    do_instr(32'h00209463, 0, lat);                       // BNE x1,x2,+8 at 0x00400014
`ifdef MC_DATAPATH_BRANCH_EXT_EN
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL bne_latency: got %0d required 4", lat); end
    @(negedge clk);
    n_checks++; if (PC !== 32'h0040001C) begin n_errors++; $display("FAIL bne_taken_pc: got %h required 0040001c", PC); end
`else
    n_checks++; if (lat !== -1 || illegal !== 1'b1) begin n_errors++; $display("FAIL bne_illegal: lat %0d illegal %b required -1 1", lat, illegal); end
    n_checks++; if (PC !== 32'h00400014) begin n_errors++; $display("FAIL bne_pc_held: got %h required 00400014", PC); end
`endif
  endtask

  task automatic test_x0_and_shifts();
    int lat;
    do_reset();
    do_instr(32'hFFB00093, 0, lat);                       // ADDI x1,x0,-5
    do_instr(32'h00700013, 0, lat);                       // ADDI x0,x0,7
    n_checks++; if (lat !== 4) begin n_errors++; $display("FAIL x0_retire: got %0d required 4", lat); end
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'hFFFFFFFB) begin n_errors++; $display("FAIL x0_no_wb: got %h required fffffffb", WriteBackData); end
    do_instr(32'h000001B3, 0, lat);                       // ADD x3,x0,x0
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'h0) begin n_errors++; $display("FAIL x0_reads_zero: got %h required 0", WriteBackData); end
    do_instr(32'h4010D393, 0, lat);                       // SRAI x7,x1,1
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL srai: got %h required fffffffd", WriteBackData); end
    do_instr(32'h01C0D413, 0, lat);                       // SRLI x8,x1,28
    @(negedge clk);
    n_checks++; if (WriteBackData !== 32'h0000000F) begin n_errors++; $display("FAIL srli: got %h required 0000000f", WriteBackData); end
  endtask

  task automatic test_misaligned();
    int   lat;
    logic bad;
    do_instr(32'h00000163, 0, lat);                       // BEQ x0,x0,+2 at INIT+0x14
    n_checks++; if (lat !== -1 || illegal !== 1'b1) begin n_errors++; $display("FAIL misaligned_illegal: lat %0d illegal %b required -1 1", lat, illegal); end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (retire || iReq || dReq || !illegal || PC !== INIT + 32'h14) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_errors++; $display("FAIL halt_hold: got %b required 0 (PC %h)", bad, PC); end
  endtask

  task automatic test_illegal_opcode();
    int lat;
    do_reset();
    do_instr(32'h0000007F, 0, lat);
    n_checks++; if (lat !== -1 || illegal !== 1'b1) begin n_errors++; $display("FAIL opcode_illegal: lat %0d illegal %b required -1 1", lat, illegal); end
    n_checks++; if (PC !== INIT) begin n_errors++; $display("FAIL opcode_pc: got %h required %h", PC, INIT); end
  endtask

  task automatic test_reset_in_mem();
    int   wait_cnt;
    logic saw_retire;
    do_reset();
    wait_cnt = 0;
    while (!iReq && wait_cnt < 10) begin @(negedge clk); wait_cnt++; end
    instr = 32'h00102423; iReady = 1'b1;                  // SW x1,8(x0), never accepted
    @(negedge clk);
    iReady = 1'b0; dReady = 1'b0; wait_cnt = 0; saw_retire = 1'b0;
    while (!dReq && wait_cnt < 10) begin
      if (retire) saw_retire = 1'b1;
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++; if (dReq !== 1'b1) begin n_errors++; $display("FAIL mem_reached: dReq %b required 1", dReq); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({dReq, dWe} !== 2'b00) begin n_errors++; $display("FAIL rst_mem_dreq: got %b required 00", {dReq, dWe}); end
    n_checks++; if (PC !== INIT) begin n_errors++; $display("FAIL rst_mem_pc: got %h required %h", PC, INIT); end
    rst = 1'b0;
    wait_cnt = 0;
    while (!iReq && wait_cnt < 10) begin
      if (retire || dReq) saw_retire = 1'b1;
      @(negedge clk);
      wait_cnt++;
    end
    n_checks++; if (iReq !== 1'b1 || iAddr !== INIT || saw_retire !== 1'b0) begin
      n_errors++; $display("FAIL rst_mem_refetch: iReq %b iAddr %h stray %b required 1 %h 0", iReq, iAddr, saw_retire, INIT);
    end
  endtask

  task automatic test_nregs16();
    int   wait_cnt;
    logic saw_retire;
    instr16 = 32'h00000A33;                               // ADD x20,x0,x0
    iReady16 = 1'b1; wait_cnt = 0; saw_retire = 1'b0;
    while (!illegal16 && wait_cnt < 20) begin
      if (iReq16) begin @(negedge clk); iReady16 = 1'b0; end
      else @(negedge clk);
      if (retire16) saw_retire = 1'b1;
      wait_cnt++;
    end
    iReady16 = 1'b0;
    n_checks++; if (illegal16 !== 1'b1 || saw_retire !== 1'b0) begin n_errors++; $display("FAIL nregs16_illegal: illegal %b retire %b required 1 0", illegal16, saw_retire); end
    n_checks++; if (PC16 !== INIT || WriteBackData16 !== 32'h0) begin n_errors++; $display("FAIL nregs16_state: PC %h wb %h required %h 0", PC16, WriteBackData16, INIT); end
    n_checks++; if ({dReq16, dWe16} !== 2'b00 || dAddress16 !== 32'h0 || dWriteData16 !== 32'h0) begin
      n_errors++; $display("FAIL nregs16_no_mem: req %b we %b addr %h data %h required 0", dReq16, dWe16, dAddress16, dWriteData16);
    end
  endtask

  initial begin
    iReady = 1'b0; dReady = 1'b0; instr = '0; iReady16 = 1'b0; instr16 = '0;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    test_reset();
    test_addi();
    test_load_store();
    test_branch();
    test_branch_ext();
    test_reset();
    test_x0_and_shifts();
    test_misaligned();
    test_illegal_opcode();
    test_reset_in_mem();
    test_nregs16();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
